burst_cache: RTL and testbench
==============================

BURST_CACHE -- requirements
Module: burst_cache

Interface
REQ-001 SHALL have parameters: ADDR_BITS, default 8, byte address width; DATA_BITS, default 8, word width; CHANNELS, default 4, LSU request ports; CACHE_LINES, default 16, direct-mapped lines; LINE_WORDS, default 4, words per line (power of 2, >=2); CNT_BITS, default 16, performance counter width.
REQ-002 SHALL have ports: clk in 1, clock; reset in 1, reset (asynchronous, active-high); reset reset, asynchronous, active-high; clock clk.
REQ-003 SHALL have LSU-side ports: read_valid in [CHANNELS]; read_address in [CHANNELS][ADDR_BITS]; read_ready out [CHANNELS]; read_data out [CHANNELS][DATA_BITS]; write_valid in [CHANNELS]; write_address in [CHANNELS][ADDR_BITS]; write_data in [CHANNELS][DATA_BITS]; write_ready out [CHANNELS].
REQ-004 SHALL have memory-side ports: mem_read_valid out 1; mem_read_address out ADDR_BITS; mem_read_ready in 1; mem_read_data in DATA_BITS; mem_write_valid out 1; mem_write_address out ADDR_BITS; mem_write_data out DATA_BITS; mem_write_ready in 1.
REQ-005 SHALL have: invalidate in 1, clears all valid bits; hit_count out CNT_BITS; miss_count out CNT_BITS.

Function
REQ-006 Address split SHALL be offset=addr[OFF-1:0], OFF=log2(LINE_WORDS); index=next log2(CACHE_LINES) bits; tag=remaining upper bits.
REQ-007 FSM states SHALL be IDLE, LOOKUP, FILL, WRITE_MEM, RESPOND, DRAIN.
REQ-008 IDLE: round-robin grant to first channel with read_valid or write_valid, searching from last_grant+1 mod CHANNELS; latch channel, op, address, write data; go LOOKUP. Read wins if one channel asserts both.
REQ-009 LOOKUP read hit (valid && tag match): capture word at offset, hit_count++, go RESPOND. Read miss: miss_count++, go FILL.
REQ-010 FILL: LINE_WORDS sequential memory reads, offsets 0..LINE_WORDS-1 of line base; mem_read_valid held with stable address until mem_read_ready; word stored on ready; valid/tag written after last word; requested word captured; then RESPOND.
REQ-011 Writes SHALL be write-through, no-write-allocate: LOOKUP write hit updates cached word (hit_count++), miss leaves array unchanged (miss_count++); then WRITE_MEM holds mem_write_valid/address/data until mem_write_ready, then RESPOND.
REQ-012 RESPOND: one-cycle pulse of read_ready (with read_data) or write_ready on granted channel only; then DRAIN.
REQ-013 DRAIN: wait until granted channel's request valid deasserts, then IDLE and update last_grant.
REQ-014 Non-granted channels SHALL see read_ready=0, write_ready=0, read_data=0 at all times.
REQ-015 Read hit latency: request valid in IDLE cycle t -> read_ready at cycle t+3.
REQ-016 invalidate SHALL clear all valid bits in the next cycle when FSM is IDLE; otherwise deferred until IDLE is reached; line being filled is left invalid.
REQ-017 Counters SHALL saturate at all-ones, never wrap.
REQ-018 mem_read_valid and mem_write_valid SHALL never be asserted simultaneously.

Reset
REQ-019 On reset: FSM=IDLE; all valid bits 0; last_grant=CHANNELS-1 (channel 0 first); all ready, valid, address and data outputs 0; counters 0.
REQ-020 Reset mid-FILL or mid-WRITE_MEM SHALL drop memory valids immediately; partial line stays invalid; no LSU response issued.

Structure
REQ-021 Package cache_pkg SHALL hold the state enum, address-split width constants and the cache_line_t struct (valid, tag, LINE_WORDS data words).
REQ-022 Round-robin grant logic SHALL be one sub-module rr_arbiter (CHANNELS; req in, last_grant in, grant index + any_req out).

Verification
REQ-023 Read ch0 addr 0x13, memory holds 0x10..0x13={A0,A1,A2,A3} -> 4 mem reads 0x10..0x13, read_data=A3, miss_count=1.
REQ-024 Repeat read ch1 addr 0x11 -> no mem traffic, read_ready exactly 3 cycles after valid, read_data=A1, hit_count=1.
REQ-025 Channels 0,2,3 request together, last_grant=0 -> service order 2,3,0.
REQ-026 Write ch0 addr 0x12 data 0x5A after fill -> mem write 0x12/0x5A, then read 0x12 hits returning 0x5A; write addr 0x40 (miss) -> no allocation, next read 0x40 misses.
REQ-027 Pulse invalidate after fill, then read 0x10 -> miss, 4 mem reads; reset asserted during 2nd fill word -> mem_read_valid low, next read 0x10 misses.
REQ-028 Hold mem_read_ready low 10 cycles during FILL -> mem_read_address stable, no LSU ready pulse.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for burst_cache: FSM states, default address split and cache line layout.
package cache_pkg;

  localparam int unsigned DEF_ADDR_BITS   = 8;
  localparam int unsigned DEF_DATA_BITS   = 8;
  localparam int unsigned DEF_CACHE_LINES = 16;
  localparam int unsigned DEF_LINE_WORDS  = 4;

  localparam int unsigned OFF_BITS = $clog2(DEF_LINE_WORDS);
  localparam int unsigned IDX_BITS = $clog2(DEF_CACHE_LINES);
  localparam int unsigned TAG_BITS = DEF_ADDR_BITS - OFF_BITS - IDX_BITS;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_FILL, ST_WRITE_MEM, ST_RESPOND, ST_DRAIN
  } state_t;

  typedef struct packed {
    logic                                          valid;
    logic [TAG_BITS-1:0]                           tag;
    logic [DEF_LINE_WORDS-1:0][DEF_DATA_BITS-1:0]  data;
  } cache_line_t;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_cache_rr_arbiter.sv
// Round-robin channel picker: first requester after the last granted channel.
module rr_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]            i_req,
  input  logic [idx_width(CHANNELS)-1:0] i_last_grant,
  output logic [idx_width(CHANNELS)-1:0] o_grant_c,
  output logic                           o_any_req_c
);

  localparam int unsigned CH_W = idx_width(CHANNELS);

  int unsigned w_cand;

  always_comb begin
    o_grant_c   = '0;
    o_any_req_c = 1'b0;
    w_cand      = 0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      w_cand = (32'(i_last_grant) + i) % CHANNELS;
      if (!o_any_req_c && i_req[CH_W'(w_cand)]) begin
        o_any_req_c = 1'b1;
        o_grant_c   = CH_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/burst_cache.sv
// Multi-channel direct-mapped read cache with burst line fill and write-through,
// no-write-allocate stores.
module burst_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CACHE_LINES = DEF_CACHE_LINES,
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned CNT_BITS    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CHANNELS-1:0]                  i_read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   i_read_address,
  output logic [CHANNELS-1:0]                  o_read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]   o_read_data,
  input  logic [CHANNELS-1:0]                  i_write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   i_write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]   i_write_data,
  output logic [CHANNELS-1:0]                  o_write_ready,
  output logic                                 o_mem_read_valid,
  output logic [ADDR_BITS-1:0]                 o_mem_read_address,
  input  logic                                 i_mem_read_ready,
  input  logic [DATA_BITS-1:0]                 i_mem_read_data,
  output logic                                 o_mem_write_valid,
  output logic [ADDR_BITS-1:0]                 o_mem_write_address,
  output logic [DATA_BITS-1:0]                 o_mem_write_data,
  input  logic                                 i_mem_write_ready,
  input  logic                                 i_invalidate,
  output logic [CNT_BITS-1:0]                  o_hit_count,
  output logic [CNT_BITS-1:0]                  o_miss_count
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(CACHE_LINES);
  localparam int unsigned TAG_W = ADDR_BITS - OFF_W - IDX_W;
  localparam int unsigned CH_W  = idx_width(CHANNELS);

  state_t                          r_state, w_next_state;
  logic [CH_W-1:0]                 r_grant, r_last_grant, w_arb_grant;
  logic                            w_any_req;
  logic                            r_op_write;
  logic [ADDR_BITS-1:0]            r_addr;
  logic [DATA_BITS-1:0]            r_wdata, r_rdata;
  logic [OFF_W-1:0]                r_fill_cnt;
  logic                            r_inv_pend;
  cache_line_t                     r_lines [CACHE_LINES];
  logic [CNT_BITS-1:0]             r_hit_count, r_miss_count;
  logic [CHANNELS-1:0]             r_read_ready, r_write_ready;
  logic [CHANNELS-1:0][DATA_BITS-1:0] r_read_data;
  logic                            r_mem_read_valid, r_mem_write_valid;
  logic [ADDR_BITS-1:0]            r_mem_read_address, r_mem_write_address;
  logic [DATA_BITS-1:0]            r_mem_write_data;

  logic [OFF_W-1:0]                w_off;
  logic [IDX_W-1:0]                w_idx;
  logic [TAG_W-1:0]                w_tag;
  cache_line_t                     w_line;
  logic                            w_hit, w_fill_hs, w_fill_last, w_wr_hs, w_drain_valid;
  logic [CHANNELS-1:0]             w_read_ready_nxt, w_write_ready_nxt;
  logic [CHANNELS-1:0][DATA_BITS-1:0] w_read_data_nxt;
  logic                            w_mem_read_valid_nxt, w_mem_write_valid_nxt;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .i_req        (i_read_valid | i_write_valid),
    .i_last_grant (r_last_grant),
    .o_grant_c    (w_arb_grant),
    .o_any_req_c  (w_any_req)
  );

  assign w_off         = r_addr[OFF_W-1:0];
  assign w_idx         = r_addr[OFF_W +: IDX_W];
  assign w_tag         = r_addr[ADDR_BITS-1 -: TAG_W];
  assign w_line        = r_lines[w_idx];
  assign w_hit         = w_line.valid && (w_line.tag == w_tag);
  assign w_fill_hs     = r_mem_read_valid && i_mem_read_ready;
  assign w_fill_last   = (r_fill_cnt == OFF_W'(LINE_WORDS - 1));
  assign w_wr_hs       = r_mem_write_valid && i_mem_write_ready;
  assign w_drain_valid = r_op_write ? i_write_valid[r_grant] : i_read_valid[r_grant];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (w_any_req) w_next_state = ST_LOOKUP;
      ST_LOOKUP:    if (r_op_write) w_next_state = ST_WRITE_MEM;
                    else if (w_hit) w_next_state = ST_RESPOND;
                    else            w_next_state = ST_FILL;
      ST_FILL:      if (w_fill_hs && w_fill_last) w_next_state = ST_RESPOND;
      ST_WRITE_MEM: if (w_wr_hs) w_next_state = ST_RESPOND;
      ST_RESPOND:   w_next_state = ST_DRAIN;
      ST_DRAIN:     if (!w_drain_valid) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered LSU and memory strobes.
  always_comb begin
    w_read_ready_nxt      = '0;
    w_write_ready_nxt     = '0;
    w_read_data_nxt       = '0;
    w_mem_read_valid_nxt  = 1'b0;
    w_mem_write_valid_nxt = 1'b0;
    if (r_state == ST_RESPOND) begin
      if (r_op_write) begin
        w_write_ready_nxt[r_grant] = 1'b1;
      end else begin
        w_read_ready_nxt[r_grant] = 1'b1;
        w_read_data_nxt[r_grant]  = r_rdata;
      end
    end
    w_mem_read_valid_nxt  = ((r_state == ST_LOOKUP) && !r_op_write && !w_hit) ||
                            ((r_state == ST_FILL) && !(w_fill_hs && w_fill_last));
    w_mem_write_valid_nxt = ((r_state == ST_LOOKUP) && r_op_write) ||
                            ((r_state == ST_WRITE_MEM) && !w_wr_hs);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant             <= '0;
      r_last_grant        <= CH_W'(CHANNELS - 1);
      r_op_write          <= 1'b0;
      r_addr              <= '0;
      r_wdata             <= '0;
      r_rdata             <= '0;
      r_fill_cnt          <= '0;
      r_inv_pend          <= 1'b0;
      r_hit_count         <= '0;
      r_miss_count        <= '0;
      r_read_ready        <= '0;
      r_write_ready       <= '0;
      r_read_data         <= '0;
      r_mem_read_valid    <= 1'b0;
      r_mem_write_valid   <= 1'b0;
      r_mem_read_address  <= '0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
      for (int i = 0; i < int'(CACHE_LINES); i++) r_lines[i] <= '0;
    end else begin
      r_read_ready      <= w_read_ready_nxt;
      r_write_ready     <= w_write_ready_nxt;
      r_read_data       <= w_read_data_nxt;
      r_mem_read_valid  <= w_mem_read_valid_nxt;
      r_mem_write_valid <= w_mem_write_valid_nxt;
      case (r_state)
        ST_IDLE: if (w_any_req) begin
          r_grant    <= w_arb_grant;
          r_op_write <= !i_read_valid[w_arb_grant];
          r_addr     <= i_read_valid[w_arb_grant] ? i_read_address[w_arb_grant]
                                                  : i_write_address[w_arb_grant];
          r_wdata    <= i_write_data[w_arb_grant];
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            if (r_hit_count != '1) r_hit_count <= r_hit_count + CNT_BITS'(1);
          end else if (r_miss_count != '1) begin
            r_miss_count <= r_miss_count + CNT_BITS'(1);
          end
          if (r_op_write) begin
            if (w_hit) r_lines[w_idx].data[w_off] <= r_wdata;
            r_mem_write_address <= r_addr;
            r_mem_write_data    <= r_wdata;
          end else if (w_hit) begin
            r_rdata <= w_line.data[w_off];
          end else begin
            // Line stays invalid until its last word lands.
            r_lines[w_idx].valid <= 1'b0;
            r_fill_cnt           <= '0;
            r_mem_read_address   <= {r_addr[ADDR_BITS-1:OFF_W], OFF_W'(0)};
          end
        end
        ST_FILL: if (w_fill_hs) begin
          r_lines[w_idx].data[r_fill_cnt] <= i_mem_read_data;
          if (r_fill_cnt == w_off) r_rdata <= i_mem_read_data;
          if (w_fill_last) begin
            r_lines[w_idx].valid <= 1'b1;
            r_lines[w_idx].tag   <= w_tag;
          end else begin
            r_fill_cnt         <= r_fill_cnt + OFF_W'(1);
            r_mem_read_address <= r_mem_read_address + ADDR_BITS'(1);
          end
        end
        ST_DRAIN: if (!w_drain_valid) r_last_grant <= r_grant;
        default: ;
      endcase
      // Invalidation is held pending until the FSM is idle.
      if ((r_state == ST_IDLE) && (i_invalidate || r_inv_pend)) begin
        r_inv_pend <= 1'b0;
        for (int i = 0; i < int'(CACHE_LINES); i++) r_lines[i].valid <= 1'b0;
      end else if (i_invalidate) begin
        r_inv_pend <= 1'b1;
      end
    end
  end

  assign o_read_ready        = r_read_ready;
  assign o_read_data         = r_read_data;
  assign o_write_ready       = r_write_ready;
  assign o_mem_read_valid    = r_mem_read_valid;
  assign o_mem_read_address  = r_mem_read_address;
  assign o_mem_write_valid   = r_mem_write_valid;
  assign o_mem_write_address = r_mem_write_address;
  assign o_mem_write_data    = r_mem_write_data;
  assign o_hit_count         = r_hit_count;
  assign o_miss_count        = r_miss_count;

endmodule

// File: tb/tb_burst_cache.sv
// Directed self-checking bench for burst_cache with a simple byte memory model.
module tb_burst_cache;

  logic clk = 1'b0;
  logic reset;
  logic [3:0]      i_read_valid, i_write_valid, o_read_ready, o_write_ready;
  logic [3:0][7:0] i_read_address, i_write_address, i_write_data, o_read_data;
  logic            o_mem_read_valid, i_mem_read_ready, o_mem_write_valid, i_mem_write_ready;
  logic [7:0]      o_mem_read_address, i_mem_read_data, o_mem_write_address, o_mem_write_data;
  logic            i_invalidate;
  logic [15:0]     o_hit_count, o_miss_count;

  logic [7:0] mem [256];
  logic [7:0] rd_q[$];
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int both_cnt = 0;

  burst_cache dut (
    .clk(clk), .reset(reset),
    .i_read_valid(i_read_valid), .i_read_address(i_read_address),
    .o_read_ready(o_read_ready), .o_read_data(o_read_data),
    .i_write_valid(i_write_valid), .i_write_address(i_write_address),
    .i_write_data(i_write_data), .o_write_ready(o_write_ready),
    .o_mem_read_valid(o_mem_read_valid), .o_mem_read_address(o_mem_read_address),
    .i_mem_read_ready(i_mem_read_ready), .i_mem_read_data(i_mem_read_data),
    .o_mem_write_valid(o_mem_write_valid), .o_mem_write_address(o_mem_write_address),
    .o_mem_write_data(o_mem_write_data), .i_mem_write_ready(i_mem_write_ready),
    .i_invalidate(i_invalidate), .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
  );

  always #5 clk = ~clk;

  assign i_mem_read_data = mem[o_mem_read_address];

  always @(posedge clk)
    if (o_mem_write_valid && i_mem_write_ready) mem[o_mem_write_address] <= o_mem_write_data;

  // Log memory handshakes that complete at the coming rising edge.
  always @(negedge clk) begin
    if (o_mem_read_valid && i_mem_read_ready) rd_q.push_back(o_mem_read_address);
    if (o_mem_write_valid && i_mem_write_ready) begin
      wa_q.push_back(o_mem_write_address);
      wd_q.push_back(o_mem_write_data);
    end
    if (o_mem_read_valid && o_mem_write_valid) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int ch, input logic [7:0] a, output logic [7:0] d, output int lat);
    i_read_address[ch] = a;
    i_read_valid[ch]   = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (o_read_ready[ch] !== 1'b1 && lat < 200);
    check("rd_ready_onehot", 32'(o_read_ready), 32'(4'b1 << ch));
    d = o_read_data[ch];
    i_read_valid[ch] = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_write(input int ch, input logic [7:0] a, input logic [7:0] wd);
    int n;
    i_write_address[ch] = a;
    i_write_data[ch]    = wd;
    i_write_valid[ch]   = 1'b1;
    n = 0;
    do begin tick(); n++; end while (o_write_ready[ch] !== 1'b1 && n < 200);
    check("wr_ready_onehot", 32'(o_write_ready), 32'(4'b1 << ch));
    i_write_valid[ch] = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
  endtask

  logic [7:0] d;
  int         lat;
  int         ord [3];
  logic [7:0] mdat [4];
  int         n_ord;
  logic [7:0] a0;
  logic       stable_ok, quiet_ok;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hA0 | 8'(i % 16);
    i_read_valid = '0; i_write_valid = '0;
    i_read_address = '0; i_write_address = '0; i_write_data = '0;
    i_mem_read_ready = 1'b1; i_mem_write_ready = 1'b1; i_invalidate = 1'b0;
    reset = 1'b1;
    tick(); tick();
    check("rst_mem_rd_valid", 32'(o_mem_read_valid), 0);
    check("rst_mem_rd_addr", 32'(o_mem_read_address), 0);
    reset = 1'b0;
    tick();
    check("rst_mem_wr_valid", 32'(o_mem_write_valid), 0);
    check("rst_rd_ready", 32'(o_read_ready), 0);
    check("rst_wr_ready", 32'(o_write_ready), 0);
    check("rst_hits", 32'(o_hit_count), 0);
    check("rst_miss", 32'(o_miss_count), 0);

    // Cold miss fills line 0x10..0x13
    clear_logs();
    do_read(0, 8'h13, d, lat);
    check("fill_data", 32'(d), 32'hA3);
    check("fill_nreads", rd_q.size(), 4);
    for (int i = 0; i < 4; i++) check("fill_addr", (rd_q.size() > i) ? 32'(rd_q[i]) : 32'hFFFF, 32'h10 + i);
    check("fill_miss", 32'(o_miss_count), 1);

    // Hit on another channel, three-cycle latency
    clear_logs();
    do_read(1, 8'h11, d, lat);
    check("hit_data", 32'(d), 32'hA1);
    check("hit_latency", lat, 3);
    check("hit_no_mem", rd_q.size(), 0);
    check("hit_count", 32'(o_hit_count), 1);

    // Make channel 0 the last grant, then contend on 0,2,3
    do_read(0, 8'h10, d, lat);
    check("hit_data_ch0", 32'(d), 32'hA0);
    i_read_address[0] = 8'h11; i_read_address[2] = 8'h12; i_read_address[3] = 8'h13;
    i_read_valid = 4'b1101;
    n_ord = 0;
    for (int i = 0; i < 3; i++) begin ord[i] = 9; mdat[i] = 8'h00; end
    for (int cyc = 0; cyc < 100 && i_read_valid != 4'b0; cyc++) begin
      tick();
      for (int c = 0; c < 4; c++)
        if (o_read_ready[c] && n_ord < 3) begin
          ord[n_ord] = c;
          mdat[n_ord] = o_read_data[c];
          n_ord++;
          i_read_valid[c] = 1'b0;
        end
    end
    i_read_valid = '0;
    tick(); tick();
    check("rr_first", ord[0], 2);
    check("rr_second", ord[1], 3);
    check("rr_third", ord[2], 0);
    check("rr_data0", 32'(mdat[0]), 32'hA2);
    check("rr_data1", 32'(mdat[1]), 32'hA3);
    check("rr_data2", 32'(mdat[2]), 32'hA1);
    check("rr_hits", 32'(o_hit_count), 5);

    // Write hit goes through to memory and updates the line
    clear_logs();
    do_write(0, 8'h12, 8'h5A);
    check("wr_nwrites", wa_q.size(), 1);
    check("wr_addr", (wa_q.size() > 0) ? 32'(wa_q[0]) : 32'hFFFF, 32'h12);
    check("wr_data", (wd_q.size() > 0) ? 32'(wd_q[0]) : 32'hFFFF, 32'h5A);
    do_read(0, 8'h12, d, lat);
    check("wr_hit_readback", 32'(d), 32'h5A);
    check("wr_hit_no_fill", rd_q.size(), 0);
    check("wr_hits", 32'(o_hit_count), 7);

    // Write miss: no allocation
    clear_logs();
    do_write(2, 8'h40, 8'h77);
    check("wrmiss_addr", (wa_q.size() > 0) ? 32'(wa_q[0]) : 32'hFFFF, 32'h40);
    check("wrmiss_miss", 32'(o_miss_count), 2);
    do_read(2, 8'h40, d, lat);
    check("noalloc_nreads", rd_q.size(), 4);
    check("noalloc_data", 32'(d), 32'h77);
    check("noalloc_miss", 32'(o_miss_count), 3);

    // Invalidate forces a refill
    i_invalidate = 1'b1; tick(); i_invalidate = 1'b0; tick();
    clear_logs();
    do_read(1, 8'h10, d, lat);
    check("inv_nreads", rd_q.size(), 4);
    check("inv_data", 32'(d), 32'hA0);
    check("inv_miss", 32'(o_miss_count), 4);

    // Reset during the second fill word
    i_invalidate = 1'b1; tick(); i_invalidate = 1'b0; tick();
    i_read_address[0] = 8'h10; i_read_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 50 && !(o_mem_read_valid && o_mem_read_address == 8'h11); cyc++) tick();
    check("rst_fill_reached_w1", 32'(o_mem_read_address), 32'h11);
    reset = 1'b1;
    #1;
    check("rst_fill_drop_valid", 32'(o_mem_read_valid), 0);
    i_read_valid = '0;
    tick();
    check("rst_fill_no_ready", 32'(o_read_ready), 0);
    reset = 1'b0;
    tick();
    clear_logs();
    do_read(0, 8'h10, d, lat);
    check("rst_refill_nreads", rd_q.size(), 4);
    check("rst_refill_data", 32'(d), 32'hA0);
    check("rst_refill_miss", 32'(o_miss_count), 1);

    // Memory stall during fill
    clear_logs();
    i_mem_read_ready = 1'b0;
    i_read_address[3] = 8'h30; i_read_valid[3] = 1'b1;
    for (int cyc = 0; cyc < 20 && !o_mem_read_valid; cyc++) tick();
    a0 = o_mem_read_address;
    check("stall_addr", 32'(a0), 32'h30);
    stable_ok = 1'b1; quiet_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_mem_read_address !== a0 || o_mem_read_valid !== 1'b1) stable_ok = 1'b0;
      if (o_read_ready !== 4'b0) quiet_ok = 1'b0;
    end
    check("stall_addr_stable", 32'(stable_ok), 1);
    check("stall_no_ready", 32'(quiet_ok), 1);
    i_mem_read_ready = 1'b1;
    i_read_valid[3] = 1'b0;
    do_read(3, 8'h30, d, lat);
    check("stall_data", 32'(d), 32'hA0);
    check("stall_nreads", rd_q.size(), 4);
    check("stall_miss", 32'(o_miss_count), 2);

    check("mem_valids_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
